// File: rtl/draw_cmd_dispatcher_if.sv
// draw_cmd_dispatcher_if: command, engine and RAM-port signals of the draw command dispatcher
interface draw_cmd_dispatcher_if #(
    parameter int CMD_WIDTH      = 32,
    parameter int NUM_ENGINES    = 4,
    parameter int FIFO_AW        = 4,
    parameter int VGA_ADDR_WIDTH = 19,
    parameter int COLOR_ID_WIDTH = 8
);
    logic [CMD_WIDTH-1:0]                   cmd_in;
    logic                                   cmd_vld;
    logic                                   cmd_rdy;
    logic                                   flush;
    logic [FIFO_AW:0]                       fifo_level;
    logic [CMD_WIDTH-1:0]                   eng_cmd;
    logic [NUM_ENGINES-1:0]                 eng_start;
    logic [NUM_ENGINES-1:0]                 eng_release;
    logic [NUM_ENGINES-1:0]                 eng_done;
    logic [NUM_ENGINES*VGA_ADDR_WIDTH-1:0]  eng_addr;
    logic [NUM_ENGINES*COLOR_ID_WIDTH-1:0]  eng_data;
    logic [NUM_ENGINES-1:0]                 eng_wren;
    logic [NUM_ENGINES-1:0]                 eng_grant;
    logic [VGA_ADDR_WIDTH-1:0]              oaddr;
    logic [COLOR_ID_WIDTH-1:0]              odata;
    logic                                   owren;
    logic                                   busy;
    logic                                   err_unknown;
    logic                                   err_timeout;
    logic [7:0]                             err_count;

    modport slave (
        input  cmd_in, cmd_vld, flush, eng_release, eng_done, eng_addr, eng_data, eng_wren,
        output cmd_rdy, fifo_level, eng_cmd, eng_start, eng_grant, oaddr, odata, owren,
               busy, err_unknown, err_timeout, err_count
    );

    modport master (
        output cmd_in, cmd_vld, flush, eng_release, eng_done, eng_addr, eng_data, eng_wren,
        input  cmd_rdy, fifo_level, eng_cmd, eng_start, eng_grant, oaddr, odata, owren,
               busy, err_unknown, err_timeout, err_count
    );
endinterface

// File: rtl/draw_cmd_dispatcher.sv
// draw_cmd_dispatcher: FIFO-buffered command dispatch to draw engines with busy tracking and RAM write arbitration
module draw_cmd_dispatcher #(
    parameter int CMD_WIDTH      = 32,
    parameter int OP_WIDTH       = 4,
    parameter int NUM_ENGINES    = 4,
    // engine 0 = 4'ha, engine 1 = 4'h9, engine 2 = 4'h1, engine 3 = 4'h0
    parameter logic [NUM_ENGINES*OP_WIDTH-1:0] ENGINE_OPCODES = {4'h0, 4'h1, 4'h9, 4'ha},
    parameter int FIFO_AW        = 4,
    parameter int VGA_ADDR_WIDTH = 19,
    parameter int COLOR_ID_WIDTH = 8,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input logic clk,
    input logic rst_n,
    draw_cmd_dispatcher_if.slave bus
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int PW    = FIFO_AW + 1;
    localparam int SW    = NUM_ENGINES > 1 ? $clog2(NUM_ENGINES) : 1;
    localparam int TW    = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, POP, ISSUE, WAIT} state_e;

    logic [CMD_WIDTH-1:0]      mem [DEPTH];
    logic [PW-1:0]             wptr_q, rptr_q, wptr_d, rptr_d, level_d;
    logic                      rdy_q, wr, rd;
    logic [CMD_WIDTH-1:0]      rdat_q, cmd_q, cmd_d;
    state_e                    state_q, state_d;
    logic [SW-1:0]             sel_q, sel_d, dsel;
    logic                      hit;
    logic [NUM_ENGINES-1:0]    start_q, start_d, ebusy_q, ebusy_d, sel_oh, clr;
    logic [TW-1:0]             tmr_q, tmr_d;
    logic                      unk_q, unk_d, tmo_q, tmo_d;
    logic [7:0]                cnt_q, cnt_d;
    logic [NUM_ENGINES-1:0]    grant;
    logic [VGA_ADDR_WIDTH-1:0] gaddr, oaddr_q;
    logic [COLOR_ID_WIDTH-1:0] gdata, odata_q;
    logic                      owren_q;

    assign wr      = bus.cmd_vld & rdy_q & ~bus.flush;
    assign wptr_d  = bus.flush ? '0 : wptr_q + PW'(wr);
    assign rptr_d  = bus.flush ? '0 : rptr_q + PW'(rd);
    assign level_d = wptr_d - rptr_d;
    assign sel_oh  = NUM_ENGINES'(1) << sel_q;

    // downward scan so the lowest matching engine index wins
    always_comb begin
        hit  = 1'b0;
        dsel = '0;
        for (int i = NUM_ENGINES - 1; i >= 0; i--)
            if (rdat_q[CMD_WIDTH-1 -: OP_WIDTH] == ENGINE_OPCODES[i*OP_WIDTH +: OP_WIDTH]) begin
                hit  = 1'b1;
                dsel = SW'(i);
            end
    end

    always_comb begin
        state_d = state_q;
        rd      = 1'b0;
        sel_d   = sel_q;
        cmd_d   = cmd_q;
        start_d = '0;
        unk_d   = 1'b0;
        tmo_d   = 1'b0;
        tmr_d   = tmr_q;
        clr     = '0;
        case (state_q)
            IDLE: if (wptr_q != rptr_q && !bus.flush) begin
                rd      = 1'b1;
                state_d = POP;
            end
            POP: begin
                cmd_d   = rdat_q;
                sel_d   = dsel;
                unk_d   = !bus.flush && !hit;
                state_d = (!bus.flush && hit) ? ISSUE : IDLE;
            end
            ISSUE: if (bus.flush) state_d = IDLE;
            else if (!ebusy_q[sel_q]) begin
                start_d = sel_oh;
                tmr_d   = '0;
                state_d = WAIT;
            end
            WAIT: if (bus.eng_done[sel_q] || bus.eng_release[sel_q]) state_d = IDLE;
            else if (TIMEOUT_CYCLES != 0 && tmr_q == TLIM) begin
                tmo_d   = 1'b1;
                clr     = sel_oh;
                state_d = IDLE;
            end else tmr_d = tmr_q + TW'(1);
            default: state_d = IDLE;
        endcase
    end

    // a start in the same cycle as a done keeps the engine busy
    assign ebusy_d = ((ebusy_q & ~bus.eng_done) | start_d) & ~clr;
    assign cnt_d   = ((unk_d || tmo_d) && cnt_q != 8'hff) ? cnt_q + 8'd1 : cnt_q;
    assign grant   = bus.eng_wren & (~bus.eng_wren + NUM_ENGINES'(1));

    always_comb begin
        gaddr = '0;
        gdata = '0;
        for (int i = 0; i < NUM_ENGINES; i++) begin
            gaddr = gaddr | ({VGA_ADDR_WIDTH{grant[i]}} & bus.eng_addr[i*VGA_ADDR_WIDTH +: VGA_ADDR_WIDTH]);
            gdata = gdata | ({COLOR_ID_WIDTH{grant[i]}} & bus.eng_data[i*COLOR_ID_WIDTH +: COLOR_ID_WIDTH]);
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wptr_q[FIFO_AW-1:0]] <= bus.cmd_in;
        if (rd) rdat_q <= mem[rptr_q[FIFO_AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            rdy_q   <= 1'b0;
            state_q <= IDLE;
            sel_q   <= '0;
            cmd_q   <= '0;
            start_q <= '0;
            ebusy_q <= '0;
            tmr_q   <= '0;
            unk_q   <= 1'b0;
            tmo_q   <= 1'b0;
            cnt_q   <= '0;
            oaddr_q <= '0;
            odata_q <= '0;
            owren_q <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            rdy_q   <= level_d != PW'(DEPTH);
            state_q <= state_d;
            sel_q   <= sel_d;
            cmd_q   <= cmd_d;
            start_q <= start_d;
            ebusy_q <= ebusy_d;
            tmr_q   <= tmr_d;
            unk_q   <= unk_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
            oaddr_q <= gaddr;
            odata_q <= gdata;
            owren_q <= |bus.eng_wren;
        end
    end

    assign bus.cmd_rdy     = rdy_q;
    assign bus.fifo_level  = wptr_q - rptr_q;
    assign bus.eng_cmd     = cmd_q;
    assign bus.eng_start   = start_q;
    assign bus.eng_grant   = grant;
    assign bus.oaddr       = oaddr_q;
    assign bus.odata       = odata_q;
    assign bus.owren       = owren_q;
    assign bus.busy        = state_q != IDLE || |ebusy_q;
    assign bus.err_unknown = unk_q;
    assign bus.err_timeout = tmo_q;
    assign bus.err_count   = cnt_q;
endmodule
